// File: rtl/gpu_pkg.sv
// Shared definitions for the instruction prefetch fetcher.
//   - default width/depth constants used as parameter defaults
//   - fetcher FSM state encoding
package gpu_pkg;

   localparam int DEFAULT_ADDRESS_BITS = 8;
   localparam int DEFAULT_DRAWER_BITS  = 16;
   localparam int DEFAULT_DEPTH        = 4;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_REQUEST = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/prefetch_fetcher_if.sv
// Program-memory read bus between the prefetch fetcher and instruction memory.
// One request is outstanding at a time: the requester holds mem_read_valid and
// mem_read_address stable until the responder pulses mem_read_ready with data.
//   master (fetcher): drives mem_read_valid, mem_read_address; takes ready/data
//   slave  (memory) : takes mem_read_valid, mem_read_address; drives ready/data
interface prefetch_fetcher_if #(
   parameter int ADDRESS_BITS = gpu_pkg::DEFAULT_ADDRESS_BITS,
   parameter int DRAWER_BITS  = gpu_pkg::DEFAULT_DRAWER_BITS
) ();

   logic                    mem_read_valid;
   logic [ADDRESS_BITS-1:0] mem_read_address;
   logic                    mem_read_ready;
   logic [DRAWER_BITS-1:0]  mem_read_data;

   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );

endinterface

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {instruction, pc} words.
//   clk, reset   : clock, asynchronous active-high reset
//   push_i       : write push_data_i at the tail (ignored when full)
//   pop_i        : advance the head (ignored when empty)
//   flush_i      : empty the queue; takes priority over push/pop
//   head_o       : word at the head (contents undefined when empty)
//   count_o      : number of stored words, 0..DEPTH
module fetch_queue
   import gpu_pkg::*;
#(
   parameter int WIDTH = DEFAULT_DRAWER_BITS + DEFAULT_ADDRESS_BITS,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [PW-1:0]    head_q, tail_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_push = push_i && !flush_i && (count_q != CW'(DEPTH));
   assign do_pop  = pop_i  && !flush_i && (count_q != '0);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) tail_q <= tail_q + PW'(1);
         if (do_pop)  head_q <= head_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; count_q gates every read of it.
   always_ff @(posedge clk) begin
      if (do_push) store_q[tail_q] <= push_data_i;
   end

   assign head_o  = store_q[head_q];
   assign count_o = count_q;

endmodule

// File: rtl/prefetch_fetcher.sv
// Instruction prefetcher: issues sequential program-memory reads into a small
// instruction queue, one request outstanding at a time, with branch redirect.
//   clk, reset          : clock, asynchronous active-high reset
//   fetch_enable        : permits new memory requests
//   redirect_valid/_pc  : flush queue and restart fetching at redirect_pc
//   mem_bus (master)    : program-memory read request/response
//   instruction_valid/instruction/instruction_pc : queue head, zero when empty
//   instruction_consume : pop the queue head
// Optional macro PREFETCH_FETCHER_PERF_EN adds perf_fetches / perf_stalls.
//
// state   | meaning
// IDLE    | no request outstanding; may issue at fetch_pc
// REQUEST | request outstanding; response is pushed to the queue
// DISCARD | request outstanding but redirected; response is dropped
module prefetch_fetcher
   import gpu_pkg::*;
#(
   parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
   parameter int DRAWER_BITS  = DEFAULT_DRAWER_BITS,
   parameter int DEPTH        = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    fetch_enable,
   input  logic                    redirect_valid,
   input  logic [ADDRESS_BITS-1:0] redirect_pc,
   prefetch_fetcher_if.master      mem_bus,
   output logic                    instruction_valid,
   output logic [DRAWER_BITS-1:0]  instruction,
   output logic [ADDRESS_BITS-1:0] instruction_pc,
   input  logic                    instruction_consume
`ifdef PREFETCH_FETCHER_PERF_EN
   ,
   output logic [31:0]             perf_fetches,
   output logic [31:0]             perf_stalls
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int QW = DRAWER_BITS + ADDRESS_BITS;

   localparam logic [1:0] ST_IDLE    = FETCH_IDLE;
   localparam logic [1:0] ST_REQUEST = FETCH_REQUEST;
   localparam logic [1:0] ST_DISCARD = FETCH_DISCARD;

   logic [1:0]              state_q, state_d;
   logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDRESS_BITS-1:0] addr_q, addr_d;
   logic                    valid_q, valid_d;
   logic                    push, pop;
   logic [QW-1:0]           head;
   logic [CW-1:0]           count;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      push       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A late ready with nothing outstanding is ignored here.
            if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
            end else if (fetch_enable && (count < CW'(DEPTH))) begin
               valid_d = 1'b1;
               addr_d  = fetch_pc_q;
               state_d = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (mem_bus.mem_read_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
               if (redirect_valid) begin
                  fetch_pc_d = redirect_pc;
               end else begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(1);
               end
            end else if (redirect_valid) begin
               fetch_pc_d = redirect_pc;
               state_d    = ST_DISCARD;
            end
         end
         ST_DISCARD: begin
            if (redirect_valid) fetch_pc_d = redirect_pc;
            if (mem_bus.mem_read_ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= '0;
         addr_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
      end
   end

   assign mem_bus.mem_read_valid   = valid_q;
   assign mem_bus.mem_read_address = addr_q;

   // A redirect flushes, so any consume in that cycle is moot.
   assign pop = instruction_consume && !redirect_valid;

   fetch_queue #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i ({mem_bus.mem_read_data, addr_q}),
      .pop_i       (pop),
      .flush_i     (redirect_valid),
      .head_o      (head),
      .count_o     (count)
   );

   assign instruction_valid = (count != '0);
   assign instruction       = instruction_valid ? head[ADDRESS_BITS +: DRAWER_BITS] : '0;
   assign instruction_pc    = instruction_valid ? head[ADDRESS_BITS-1:0] : '0;

`ifdef PREFETCH_FETCHER_PERF_EN
   logic [31:0] perf_fetches_q, perf_stalls_q;
   logic [CW:0] occupancy;
   logic        stall;

   // Stall: fetching wanted but queue plus the in-flight slot is full.
   assign occupancy = {1'b0, count} + (CW+1)'(state_q != ST_IDLE);
   assign stall     = fetch_enable && (occupancy == (CW+1)'(DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetches_q <= '0;
         perf_stalls_q  <= '0;
      end else begin
         if (push && (perf_fetches_q != '1)) perf_fetches_q <= perf_fetches_q + 32'd1;
         if (stall && (perf_stalls_q != '1)) perf_stalls_q <= perf_stalls_q + 32'd1;
      end
   end

   assign perf_fetches = perf_fetches_q;
   assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_prefetch_fetcher.sv
module tb_prefetch_fetcher;
   import gpu_pkg::*;

   localparam int AB    = 8;
   localparam int DB    = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          fetch_enable = 1'b0;
   logic          redirect_valid = 1'b0;
   logic [AB-1:0] redirect_pc = '0;
   logic          instruction_consume = 1'b0;
   logic          instruction_valid;
   logic [DB-1:0] instruction;
   logic [AB-1:0] instruction_pc;
`ifdef PREFETCH_FETCHER_PERF_EN
   logic [31:0]   perf_fetches, perf_stalls;
`endif

   prefetch_fetcher_if #(.ADDRESS_BITS(AB), .DRAWER_BITS(DB)) mem_if ();

   prefetch_fetcher #(
      .ADDRESS_BITS (AB),
      .DRAWER_BITS  (DB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .fetch_enable        (fetch_enable),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc),
      .mem_bus             (mem_if),
      .instruction_valid   (instruction_valid),
      .instruction         (instruction),
      .instruction_pc      (instruction_pc),
      .instruction_consume (instruction_consume)
`ifdef PREFETCH_FETCHER_PERF_EN
      ,
      .perf_fetches        (perf_fetches),
      .perf_stalls         (perf_stalls)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a queue of fetched words, the fetch pointer and the
   // single outstanding request (address, and whether it is to be dropped).
   typedef struct packed {
      logic [DB-1:0] data;
      logic [AB-1:0] pc;
   } ent_t;

   ent_t          mq[$];
   logic [AB-1:0] m_fetch_pc;
   logic [AB-1:0] m_req_addr;
   bit            m_busy;
   bit            m_drop;
   int            m_fetches;
   int            m_stalls;
   bit            resp_seen;

   task automatic model_reset();
      mq.delete();
      m_fetch_pc = '0;
      m_req_addr = '0;
      m_busy     = 1'b0;
      m_drop     = 1'b0;
      m_fetches  = 0;
      m_stalls   = 0;
   endtask

   task automatic model_step();
      int   pre;
      ent_t e;
      if (reset) begin
         model_reset();
         return;
      end
      pre = mq.size();
      if (fetch_enable && (pre + (m_busy ? 1 : 0) == DEPTH)) m_stalls++;
      if (instruction_consume && !redirect_valid && pre > 0) void'(mq.pop_front());
      if (m_busy) begin
         if (mem_if.mem_read_ready) begin
            if (!m_drop && !redirect_valid) begin
               e.data = mem_if.mem_read_data;
               e.pc   = m_req_addr;
               mq.push_back(e);
               m_fetch_pc = m_fetch_pc + 1'b1;
               m_fetches++;
            end
            m_busy = 1'b0;
         end else if (redirect_valid) begin
            m_drop = 1'b1;
         end
      end else if (!redirect_valid && fetch_enable && pre < DEPTH) begin
         m_busy     = 1'b1;
         m_drop     = 1'b0;
         m_req_addr = m_fetch_pc;
      end
      if (redirect_valid) begin
         mq.delete();
         m_fetch_pc = redirect_pc;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Memory answers one cycle after it first sees a request; data = 0x1000+addr.
   task automatic respond();
      if (mem_if.mem_read_valid) begin
         if (resp_seen) begin
            mem_if.mem_read_ready = 1'b1;
            resp_seen = 1'b0;
         end else begin
            mem_if.mem_read_ready = 1'b0;
            resp_seen = 1'b1;
         end
      end else begin
         mem_if.mem_read_ready = 1'b0;
         resp_seen = 1'b0;
      end
      mem_if.mem_read_data = 16'h1000 + DB'(mem_if.mem_read_address);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      fetch_enable = 1'b0;
      redirect_valid = 1'b0;
      instruction_consume = 1'b0;
      mem_if.mem_read_ready = 1'b0;
      mem_if.mem_read_data = '0;
      resp_seen = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #2;
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid got %b want 0", mem_if.mem_read_valid);
      end
      n_checks++;
      if (mem_if.mem_read_address !== 8'h00) begin
         n_fail++; $display("FAIL reset_addr got %h want 00", mem_if.mem_read_address);
      end
      n_checks++;
      if (instruction_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_ivalid got %b want 0", instruction_valid);
      end
      n_checks++;
      if (instruction !== 16'h0000) begin
         n_fail++; $display("FAIL reset_instr got %h want 0000", instruction);
      end
      n_checks++;
      if (instruction_pc !== 8'h00) begin
         n_fail++; $display("FAIL reset_pc got %h want 00", instruction_pc);
      end
   endtask

   task automatic test_fill();
      logic [AB-1:0] issued[$];
      do_reset();
      fetch_enable = 1'b1;
      for (int c = 0; c < 30; c++) begin
         respond();
         if (mem_if.mem_read_ready) issued.push_back(mem_if.mem_read_address);
         if (c >= 20) begin
            n_checks++;
            if (mem_if.mem_read_valid !== 1'b0) begin
               n_fail++; $display("FAIL fill_no_issue_when_full cycle %0d got %b want 0", c, mem_if.mem_read_valid);
            end
         end
         tick();
      end
      n_checks++;
      if (issued.size() != 4) begin
         n_fail++; $display("FAIL fill_issue_count got %0d want 4", issued.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (issued.size() <= i || issued[i] !== AB'(i)) begin
            n_fail++; $display("FAIL fill_issue_addr[%0d] got %h want %h", i,
                               (issued.size() > i) ? issued[i] : 8'hxx, AB'(i));
         end
      end
      n_checks++;
      if (instruction_valid !== 1'b1 || instruction !== 16'h1000 || instruction_pc !== 8'h00) begin
         n_fail++; $display("FAIL fill_head got v=%b %h@%h want v=1 1000@00",
                            instruction_valid, instruction, instruction_pc);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) begin
         respond();
         n_checks++;
         if (instruction_pc !== AB'(i) || instruction !== (16'h1000 + DB'(i))) begin
            n_fail++; $display("FAIL drain_head[%0d] got %h@%h want %h@%h", i, instruction,
                               instruction_pc, 16'h1000 + DB'(i), AB'(i));
         end
         if (i == 2) begin
            n_checks++;
            if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== 8'h04) begin
               n_fail++; $display("FAIL drain_refetch got v=%b addr=%h want v=1 addr=04",
                                  mem_if.mem_read_valid, mem_if.mem_read_address);
            end
         end
         instruction_consume = 1'b1;
         tick();
      end
      instruction_consume = 1'b0;
      n_checks++;
      if (instruction_valid !== 1'b1 || instruction_pc !== 8'h04 || instruction !== 16'h1004) begin
         n_fail++; $display("FAIL drain_after got v=%b %h@%h want v=1 1004@04",
                            instruction_valid, instruction, instruction_pc);
      end
   endtask

   task automatic test_redirect_request();
      do_reset();
      fetch_enable = 1'b1;
      for (int k = 0; k < 10 && !mem_if.mem_read_valid; k++) tick();
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b1) begin
         n_fail++; $display("FAIL redir_wait_issue got %b want 1 (timeout)", mem_if.mem_read_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = 8'h40;
      tick();
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== 8'h00) begin
            n_fail++; $display("FAIL redir_hold[%0d] got v=%b addr=%h want v=1 addr=00", k,
                               mem_if.mem_read_valid, mem_if.mem_read_address);
         end
         tick();
      end
      mem_if.mem_read_ready = 1'b1;
      mem_if.mem_read_data = 16'hBEEF;
      tick();
      mem_if.mem_read_ready = 1'b0;
      n_checks++;
      if (instruction_valid !== 1'b0 || mem_if.mem_read_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_dropped got ivalid=%b valid=%b want 0 0",
                            instruction_valid, mem_if.mem_read_valid);
      end
      for (int k = 0; k < 10 && !mem_if.mem_read_valid; k++) tick();
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== 8'h40) begin
         n_fail++; $display("FAIL redir_next_addr got v=%b addr=%h want v=1 addr=40",
                            mem_if.mem_read_valid, mem_if.mem_read_address);
      end
      n_checks++;
      if (instruction_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_queue_empty got %b want 0", instruction_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc = 8'hFF;
      tick();
      redirect_valid = 1'b0;
      fetch_enable = 1'b1;
      for (int k = 0; k < 20 && !instruction_valid; k++) begin
         respond();
         tick();
      end
      n_checks++;
      if (instruction_valid !== 1'b1 || instruction_pc !== 8'hFF || instruction !== 16'h10FF) begin
         n_fail++; $display("FAIL wrap_head got v=%b %h@%h want v=1 10FF@FF",
                            instruction_valid, instruction, instruction_pc);
      end
      for (int k = 0; k < 20 && !mem_if.mem_read_valid; k++) begin
         respond();
         tick();
      end
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== 8'h00) begin
         n_fail++; $display("FAIL wrap_next_addr got v=%b addr=%h want v=1 addr=00",
                            mem_if.mem_read_valid, mem_if.mem_read_address);
      end
   endtask

   task automatic test_redirect_collide();
      do_reset();
      fetch_enable = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (instruction_valid && mem_if.mem_read_valid) break;
         respond();
         tick();
      end
      n_checks++;
      if (instruction_valid !== 1'b1 || mem_if.mem_read_valid !== 1'b1) begin
         n_fail++; $display("FAIL collide_setup got ivalid=%b valid=%b want 1 1 (timeout)",
                            instruction_valid, mem_if.mem_read_valid);
      end
      redirect_valid = 1'b1;
      redirect_pc = 8'h77;
      instruction_consume = 1'b1;
      mem_if.mem_read_ready = 1'b1;
      mem_if.mem_read_data = 16'hDEAD;
      tick();
      redirect_valid = 1'b0;
      instruction_consume = 1'b0;
      mem_if.mem_read_ready = 1'b0;
      resp_seen = 1'b0;
      n_checks++;
      if (instruction_valid !== 1'b0 || instruction !== 16'h0000 || instruction_pc !== 8'h00) begin
         n_fail++; $display("FAIL collide_flush got v=%b %h@%h want v=0 0000@00",
                            instruction_valid, instruction, instruction_pc);
      end
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b0) begin
         n_fail++; $display("FAIL collide_valid got %b want 0", mem_if.mem_read_valid);
      end
      for (int k = 0; k < 10 && !mem_if.mem_read_valid; k++) tick();
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b1 || mem_if.mem_read_address !== 8'h77) begin
         n_fail++; $display("FAIL collide_next_addr got v=%b addr=%h want v=1 addr=77",
                            mem_if.mem_read_valid, mem_if.mem_read_address);
      end
      n_checks++;
      if (instruction_valid !== 1'b0) begin
         n_fail++; $display("FAIL collide_no_push got %b want 0", instruction_valid);
      end
   endtask

   task automatic test_reset_midrequest();
      do_reset();
      fetch_enable = 1'b1;
      for (int k = 0; k < 10 && !mem_if.mem_read_valid; k++) tick();
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_wait_issue got %b want 1 (timeout)", mem_if.mem_read_valid);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_if.mem_read_valid !== 1'b0 || mem_if.mem_read_address !== 8'h00) begin
         n_fail++; $display("FAIL rstmid_immediate got v=%b addr=%h want v=0 addr=00",
                            mem_if.mem_read_valid, mem_if.mem_read_address);
      end
      tick();
      reset = 1'b0;
      fetch_enable = 1'b0;
      mem_if.mem_read_ready = 1'b1;
      mem_if.mem_read_data = 16'h5555;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (instruction_valid !== 1'b0 || mem_if.mem_read_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_late_ready[%0d] got ivalid=%b valid=%b want 0 0", k,
                               instruction_valid, mem_if.mem_read_valid);
         end
      end
      mem_if.mem_read_ready = 1'b0;
`ifdef PREFETCH_FETCHER_PERF_EN
      n_checks++;
      if (perf_fetches !== 32'd0 || perf_stalls !== 32'd0) begin
         n_fail++; $display("FAIL rstmid_perf got fetches=%0d stalls=%0d want 0 0",
                            perf_fetches, perf_stalls);
      end
`endif
   endtask

   task automatic test_random();
      ent_t          exp_head;
      logic          exp_iv;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         fetch_enable          = ($urandom_range(0, 9) < 7);
         redirect_valid        = ($urandom_range(0, 24) == 0);
         redirect_pc           = AB'($urandom);
         instruction_consume   = ($urandom_range(0, 9) < 4);
         mem_if.mem_read_ready = $urandom_range(0, 1) == 1;
         mem_if.mem_read_data  = DB'($urandom);
         tick();
         exp_iv   = (mq.size() > 0);
         exp_head = exp_iv ? mq[0] : '0;
         n_checks++;
         if (mem_if.mem_read_valid !== m_busy) begin
            n_fail++; $display("FAIL rand_valid cycle %0d got %b want %b", c, mem_if.mem_read_valid, m_busy);
         end
         if (m_busy) begin
            n_checks++;
            if (mem_if.mem_read_address !== m_req_addr) begin
               n_fail++; $display("FAIL rand_addr cycle %0d got %h want %h", c,
                                  mem_if.mem_read_address, m_req_addr);
            end
         end
         n_checks++;
         if (instruction_valid !== exp_iv || instruction !== exp_head.data ||
             instruction_pc !== exp_head.pc) begin
            n_fail++; $display("FAIL rand_head cycle %0d got v=%b %h@%h want v=%b %h@%h", c,
                               instruction_valid, instruction, instruction_pc,
                               exp_iv, exp_head.data, exp_head.pc);
         end
`ifdef PREFETCH_FETCHER_PERF_EN
         n_checks++;
         if (perf_fetches !== 32'(m_fetches) || perf_stalls !== 32'(m_stalls)) begin
            n_fail++; $display("FAIL rand_perf cycle %0d got %0d/%0d want %0d/%0d", c,
                               perf_fetches, perf_stalls, m_fetches, m_stalls);
         end
`endif
      end
   endtask

   initial begin
      mem_if.mem_read_ready = 1'b0;
      mem_if.mem_read_data  = '0;
      resp_seen = 1'b0;
      model_reset();
      #2;
      test_reset();
      test_fill();
      test_drain();
      test_redirect_request();
      test_wrap();
      test_redirect_collide();
      test_reset_midrequest();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
